// File: rtl/ftdi_arbiter_if.sv
// Signal bundle between the FTDI arbiter, its RX consumer / TX producer and the FTDI interface.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface ftdi_arbiter_if;
  logic       rx_req;
  logic [9:0] rx_len;
  logic       rx_done;
  logic [9:0] rx_count;
  logic       tx_req;
  logic [9:0] tx_len;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ack;
  logic       tx_done;
  logic       err_timeout;
  logic       ftdi_rd_en;
  logic       ftdi_wr_en;
  logic [9:0] ftdi_max_rd_ct;
  logic       ftdi_rd_ct_clear;
  logic [9:0] ftdi_rd_ct;
  logic       ftdi_wr_ack;
  logic [7:0] ftdi_data_wr;
  logic       ftdi_data_wr_valid;

  modport master (
    input  rx_req, rx_len, tx_req, tx_len, tx_data, tx_data_valid, ftdi_rd_ct, ftdi_wr_ack,
    output rx_done, rx_count, tx_data_ack, tx_done, err_timeout, ftdi_rd_en, ftdi_wr_en,
           ftdi_max_rd_ct, ftdi_rd_ct_clear, ftdi_data_wr, ftdi_data_wr_valid
  );

  modport slave (
    output rx_req, rx_len, tx_req, tx_len, tx_data, tx_data_valid, ftdi_rd_ct, ftdi_wr_ack,
    input  rx_done, rx_count, tx_data_ack, tx_done, err_timeout, ftdi_rd_en, ftdi_wr_en,
           ftdi_max_rd_ct, ftdi_rd_ct_clear, ftdi_data_wr, ftdi_data_wr_valid
  );
endinterface

// File: rtl/ftdi_arbiter.sv
// Round-robin arbiter sharing one half-duplex FTDI interface between an RX consumer and a TX
// producer, with a per-grant progress timeout and a quiet guard interval between grants.
module ftdi_arbiter #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000,
  parameter int          GUARD_CYCLES   = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  ftdi_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_START,
    S_RX_ACTIVE,
    S_TX_ACTIVE,
    S_GUARD
  } state_t;

  localparam logic [15:0] GUARD_LOAD  = 16'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);
  localparam state_t      POST_STATE  = (GUARD_CYCLES > 0) ? S_GUARD : S_IDLE;
  localparam logic [19:0] TIMER_LAST  = TIMEOUT_CYCLES - 20'd1;

  function automatic logic [9:0] clamp_len(input logic [9:0] len);
    return (len > 10'd512) ? 10'd512 : len;
  endfunction

  state_t      r_state;
  logic        r_last_tx;
  logic [9:0]  r_tx_len;
  logic [9:0]  r_sent;
  logic [9:0]  r_prev_rd_ct;
  logic [9:0]  r_rx_count;
  logic [9:0]  r_max_rd_ct;
  logic [19:0] r_timer;
  logic [15:0] r_guard;
  logic        r_rd_en;
  logic        r_wr_en;
  logic        r_rd_ct_clear;
  logic        r_rx_done;
  logic        r_tx_done;
  logic        r_err;

  logic       w_grant_rx;
  logic       w_grant_tx;
  logic [9:0] w_rx_eff;
  logic       w_in_tx;
  logic       w_tx_ack;
  logic       w_rd_progress;
  logic       w_timeout;

  // Round-robin: on a tie the requester that was not granted last wins.
  assign w_grant_rx    = bus.rx_req && (!bus.tx_req || r_last_tx);
  assign w_grant_tx    = bus.tx_req && !w_grant_rx;
  assign w_rx_eff      = clamp_len(bus.rx_len);
  assign w_in_tx       = (r_state == S_TX_ACTIVE);
  assign w_tx_ack      = w_in_tx && bus.ftdi_wr_ack && (r_sent < r_tx_len);
  assign w_rd_progress = (bus.ftdi_rd_ct != r_prev_rd_ct);
  assign w_timeout     = (r_timer == TIMER_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_last_tx     <= 1'b1;
      r_tx_len      <= '0;
      r_sent        <= '0;
      r_prev_rd_ct  <= '0;
      r_rx_count    <= '0;
      r_max_rd_ct   <= '0;
      r_timer       <= '0;
      r_guard       <= '0;
      r_rd_en       <= 1'b0;
      r_wr_en       <= 1'b0;
      r_rd_ct_clear <= 1'b0;
      r_rx_done     <= 1'b0;
      r_tx_done     <= 1'b0;
      r_err         <= 1'b0;
    end else if (clear) begin
      // Same as reset except the last RX byte count survives.
      r_state       <= S_IDLE;
      r_last_tx     <= 1'b1;
      r_tx_len      <= '0;
      r_sent        <= '0;
      r_prev_rd_ct  <= '0;
      r_max_rd_ct   <= '0;
      r_timer       <= '0;
      r_guard       <= '0;
      r_rd_en       <= 1'b0;
      r_wr_en       <= 1'b0;
      r_rd_ct_clear <= 1'b0;
      r_rx_done     <= 1'b0;
      r_tx_done     <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rx_done     <= 1'b0;
      r_tx_done     <= 1'b0;
      r_err         <= 1'b0;
      r_rd_ct_clear <= 1'b0;
      r_prev_rd_ct  <= bus.ftdi_rd_ct;
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (w_grant_rx) begin
            r_last_tx <= 1'b0;
            if (bus.rx_len == 10'd0) begin
              r_rx_done  <= 1'b1;
              r_rx_count <= '0;
              r_guard    <= GUARD_LOAD;
              r_state    <= POST_STATE;
            end else begin
              r_rd_ct_clear <= 1'b1;
              r_max_rd_ct   <= w_rx_eff;
              r_state       <= S_RX_START;
            end
          end else if (w_grant_tx) begin
            r_last_tx <= 1'b1;
            r_tx_len  <= bus.tx_len;
            r_sent    <= '0;
            if (bus.tx_len == 10'd0) begin
              r_tx_done <= 1'b1;
              r_guard   <= GUARD_LOAD;
              r_state   <= POST_STATE;
            end else begin
              r_wr_en <= 1'b1;
              r_state <= S_TX_ACTIVE;
            end
          end
        end
        S_RX_START: begin
          r_timer <= '0;
          r_rd_en <= 1'b1;
          r_state <= S_RX_ACTIVE;
        end
        S_RX_ACTIVE: begin
          if (bus.ftdi_rd_ct >= r_max_rd_ct || (w_timeout && !w_rd_progress)) begin
            r_err      <= (bus.ftdi_rd_ct < r_max_rd_ct);
            r_rx_count <= bus.ftdi_rd_ct;
            r_rx_done  <= 1'b1;
            r_rd_en    <= 1'b0;
            r_guard    <= GUARD_LOAD;
            r_state    <= POST_STATE;
          end else begin
            r_timer <= w_rd_progress ? 20'd0 : (r_timer + 20'd1);
          end
        end
        S_TX_ACTIVE: begin
          if (w_tx_ack) begin
            r_sent  <= r_sent + 10'd1;
            r_timer <= '0;
            if (r_sent + 10'd1 == r_tx_len) begin
              r_tx_done <= 1'b1;
              r_wr_en   <= 1'b0;
              r_guard   <= GUARD_LOAD;
              r_state   <= POST_STATE;
            end
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_tx_done <= 1'b1;
            r_wr_en   <= 1'b0;
            r_guard   <= GUARD_LOAD;
            r_state   <= POST_STATE;
          end else begin
            r_timer <= r_timer + 20'd1;
          end
        end
        S_GUARD: begin
          if (r_guard == 16'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_guard <= r_guard - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_done            = r_rx_done;
  assign bus.rx_count           = r_rx_count;
  assign bus.tx_done            = r_tx_done;
  assign bus.err_timeout        = r_err;
  assign bus.ftdi_rd_en         = r_rd_en;
  assign bus.ftdi_wr_en         = r_wr_en;
  assign bus.ftdi_max_rd_ct     = r_max_rd_ct;
  assign bus.ftdi_rd_ct_clear   = r_rd_ct_clear;
  assign bus.tx_data_ack        = w_in_tx && bus.ftdi_wr_ack;
  assign bus.ftdi_data_wr       = w_in_tx ? bus.tx_data : 8'd0;
  assign bus.ftdi_data_wr_valid = w_in_tx && bus.tx_data_valid && (r_sent < r_tx_len);

endmodule

// File: tb/tb_ftdi_arbiter.sv
// Randomized self-checking bench for ftdi_arbiter: a transaction-level model predicts grant order,
// byte counts and handshake timing while a small FTDI responder feeds read counts and write acks.
module tb_ftdi_arbiter;
  localparam int TMO = 16;

  logic clock = 1'b0;
  logic reset_n;
  logic clear;

  ftdi_arbiter_if bus();

  ftdi_arbiter #(.TIMEOUT_CYCLES(20'd16), .GUARD_CYCLES(2)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int kind;
    int cnt;
    int err;
    int cyc;
    int start;
    int active;
  } done_t;

  done_t dq[$];
  int  n_checks = 0;
  int  n_errs   = 0;
  int  cyc      = 0;
  int  acks     = 0;
  int  wr_act   = 0;
  int  rd_act   = 0;
  int  start_cyc = 0;
  bit  prev_wr_en = 1'b0;
  bit  no_ack   = 1'b0;
  int  rd_limit = 1023;
  int  rd_stall = 0;
  int  tx_stall = 0;
  bit  last_tx  = 1'b1;

  function automatic int eff(input int len);
    return (len > 512) ? 512 : len;
  endfunction

  function automatic int pick_len();
    int r;
    r = int'($urandom_range(15));
    if (r == 0) return 0;
    if (r == 1) return 513 + int'($urandom_range(186));
    return 1 + int'($urandom_range(47));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic monitor();
    chk("rd_wr_exclusive", 32'(bus.ftdi_rd_en & bus.ftdi_wr_en), 32'd0);
    chk("tx_data_ack", 32'(bus.tx_data_ack), 32'(bus.ftdi_wr_en & bus.ftdi_wr_ack));
    if (bus.ftdi_wr_en) begin
      if (!prev_wr_en) begin
        acks = 0; wr_act = 0; start_cyc = cyc;
      end
      chk("wr_data", 32'(bus.ftdi_data_wr), 32'(bus.tx_data));
      chk("wr_valid", 32'(bus.ftdi_data_wr_valid),
          32'(bus.tx_data_valid && (acks < int'(bus.tx_len))));
      wr_act++;
      if (bus.ftdi_wr_ack) acks++;
    end else begin
      chk("wr_valid_off", 32'(bus.ftdi_data_wr_valid), 32'd0);
    end
    prev_wr_en = bus.ftdi_wr_en;
    if (bus.ftdi_rd_ct_clear) begin
      chk("max_rd_ct", 32'(bus.ftdi_max_rd_ct), 32'(eff(int'(bus.rx_len))));
      rd_act = 0; start_cyc = cyc;
    end
    if (bus.ftdi_rd_en) rd_act++;
    if (bus.err_timeout) chk("err_with_done", 32'(bus.rx_done | bus.tx_done), 32'd1);
    if (bus.rx_done) begin
      dq.push_back('{0, int'(bus.rx_count), int'(bus.err_timeout), cyc, start_cyc, rd_act});
      rd_act = 0;
    end
    if (bus.tx_done) begin
      dq.push_back('{1, acks, int'(bus.err_timeout), cyc, start_cyc, wr_act});
      acks = 0; wr_act = 0;
    end
  endtask

  // One clock: FTDI responder acts just after the edge, checks run on the falling edge.
  task automatic cycle();
    @(posedge clock);
    #1;
    cyc++;
    if (bus.ftdi_rd_ct_clear) begin
      bus.ftdi_rd_ct = 10'd0;
    end else if (bus.ftdi_rd_en && bus.ftdi_rd_ct < bus.ftdi_max_rd_ct &&
                 int'(bus.ftdi_rd_ct) < rd_limit) begin
      if ($urandom_range(3) != 0 || rd_stall >= 6) begin
        bus.ftdi_rd_ct = bus.ftdi_rd_ct + 10'd1;
        rd_stall = 0;
      end else begin
        rd_stall++;
      end
    end
    bus.tx_data       = 8'($urandom);
    bus.tx_data_valid = ($urandom_range(3) != 0) || (tx_stall >= 4);
    #1;
    if (bus.ftdi_wr_en) begin
      bus.ftdi_wr_ack = bus.ftdi_data_wr_valid && !no_ack &&
                        (($urandom_range(3) != 0) || (tx_stall >= 4));
      tx_stall = bus.ftdi_wr_ack ? 0 : tx_stall + 1;
    end else begin
      bus.ftdi_wr_ack = ($urandom_range(7) == 0);
      tx_stall = 0;
    end
    @(negedge clock);
    monitor();
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (dq.size() == 0 && b < 3000) begin
      cycle();
      b++;
    end
    if (dq.size() == 0) chk("done_seen", 32'(dq.size()), 32'd1);
  endtask

  task automatic expect_done(input string tag, input int kind, input int cnt, input int err,
                             output done_t d);
    if (dq.size() == 0) begin
      d = '{-1, -1, -1, -1, -1, -1};
    end else begin
      d = dq.pop_front();
      chk({tag, "_kind"}, 32'(d.kind), 32'(kind));
      chk({tag, "_count"}, 32'(d.cnt), 32'(cnt));
      chk({tag, "_err"}, 32'(d.err), 32'(err));
    end
  endtask

  // mode 0: RX only, 1: TX only, 2: both held until both grants finish.
  task automatic run_txn(input int mode);
    int rl, tl, set_cyc, first, second, len1, len2;
    done_t d1, d2;
    rl = pick_len();
    tl = pick_len();
    bus.rx_len = 10'(rl);
    bus.tx_len = 10'(tl);
    bus.rx_req = (mode != 1);
    bus.tx_req = (mode != 0);
    set_cyc = cyc;
    first = (mode == 0) ? 0 : (mode == 1) ? 1 : (last_tx ? 0 : 1);
    len1  = first ? tl : eff(rl);
    wait_done();
    if (mode != 2) begin
      bus.rx_req = 1'b0; bus.tx_req = 1'b0;
    end
    expect_done("grant1", first, len1, 0, d1);
    if (len1 > 0) chk("grant_latency", 32'(d1.start), 32'(set_cyc + 1));
    else begin
      chk("zero_latency", 32'(d1.cyc), 32'(set_cyc + 1));
      chk("zero_no_enable", 32'(d1.active), 32'd0);
    end
    last_tx = (first == 1);
    if (mode == 2) begin
      second = 1 - first;
      len2 = second ? tl : eff(rl);
      wait_done();
      bus.rx_req = 1'b0; bus.tx_req = 1'b0;
      expect_done("grant2", second, len2, 0, d2);
      if (len2 > 0) chk("guard_gap", 32'(d2.start - d1.cyc), 32'd3);
      else          chk("guard_gap_zero", 32'(d2.cyc - d1.cyc), 32'd3);
      last_tx = (second == 1);
    end
    cycle();
    cycle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    done_t d;
    int b;
    reset_n = 1'b0;
    clear   = 1'b0;
    bus.rx_req = 1'b0; bus.rx_len = '0; bus.tx_req = 1'b0; bus.tx_len = '0;
    bus.tx_data = '0; bus.tx_data_valid = 1'b0; bus.ftdi_rd_ct = '0; bus.ftdi_wr_ack = 1'b0;
    repeat (3) cycle();
    chk("reset_flags", 32'({bus.ftdi_rd_en, bus.ftdi_wr_en, bus.ftdi_rd_ct_clear, bus.rx_done,
                            bus.tx_done, bus.err_timeout, bus.tx_data_ack,
                            bus.ftdi_data_wr_valid}), 32'd0);
    chk("reset_max_rd_ct", 32'(bus.ftdi_max_rd_ct), 32'd0);
    chk("reset_rx_count", 32'(bus.rx_count), 32'd0);
    reset_n = 1'b1;
    cycle();

    run_txn(2);
    for (int i = 0; i < 24; i++) run_txn(int'($urandom_range(2)));

    // TX grant with no acks must abort after the full timeout.
    no_ack = 1'b1;
    bus.tx_len = 10'd5; bus.tx_req = 1'b1;
    wait_done();
    bus.tx_req = 1'b0;
    expect_done("tx_timeout", 1, 0, 1, d);
    chk("tx_timeout_cycles", 32'(d.active), 32'(TMO));
    no_ack = 1'b0; last_tx = 1'b1;
    cycle(); cycle();

    // RX stalls at 3 bytes; abort reports the partial count.
    rd_limit = 3;
    bus.rx_len = 10'd10; bus.rx_req = 1'b1;
    wait_done();
    bus.rx_req = 1'b0;
    expect_done("rx_timeout", 0, 3, 1, d);
    rd_limit = 1023; last_tx = 1'b0;
    cycle(); cycle();

    // Oversized RX request is clamped to 512.
    bus.rx_len = 10'd700; bus.rx_req = 1'b1;
    wait_done();
    bus.rx_req = 1'b0;
    expect_done("rx_clamp", 0, 512, 0, d);
    last_tx = 1'b0;
    cycle(); cycle();

    // Clear mid-TX: enables drop, no done, rx_count held, round-robin back to TX-last.
    no_ack = 1'b1;
    bus.tx_len = 10'd20; bus.tx_req = 1'b1;
    b = 0;
    while (!bus.ftdi_wr_en && b < 10) begin cycle(); b++; end
    chk("clr_tx_started", 32'(bus.ftdi_wr_en), 32'd1);
    cycle(); cycle();
    clear = 1'b1;
    cycle();
    chk("clr_wr_en", 32'(bus.ftdi_wr_en), 32'd0);
    chk("clr_tx_done", 32'(bus.tx_done), 32'd0);
    chk("clr_rx_count", 32'(bus.rx_count), 32'd512);
    chk("clr_max_rd_ct", 32'(bus.ftdi_max_rd_ct), 32'd0);
    clear = 1'b0; bus.tx_req = 1'b0; no_ack = 1'b0;
    repeat (3) cycle();
    chk("clr_no_done", 32'(dq.size()), 32'd0);
    acks = 0; wr_act = 0; last_tx = 1'b1;
    run_txn(2);

    // Asynchronous reset mid-RX drops the read enable before any clock edge.
    bus.rx_len = 10'd300; bus.rx_req = 1'b1;
    b = 0;
    while (!bus.ftdi_rd_en && b < 10) begin cycle(); b++; end
    chk("rst_rx_started", 32'(bus.ftdi_rd_en), 32'd1);
    cycle(); cycle();
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_rd_en", 32'(bus.ftdi_rd_en), 32'd0);
    chk("rst_rx_count", 32'(bus.rx_count), 32'd0);
    chk("rst_max_rd_ct", 32'(bus.ftdi_max_rd_ct), 32'd0);
    chk("rst_flags", 32'({bus.ftdi_wr_en, bus.ftdi_rd_ct_clear, bus.rx_done, bus.tx_done,
                          bus.err_timeout}), 32'd0);
    bus.rx_req = 1'b0; bus.ftdi_rd_ct = '0;
    rd_act = 0; acks = 0; wr_act = 0; last_tx = 1'b1;
    cycle();
    reset_n = 1'b1;
    cycle();
    run_txn(2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/ftdi_arbiter.md
FTDI_ARBITER -- requirements
Module: ftdi_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20'd1000000: idle cycles without byte progress before a grant is aborted.
REQ-002 Parameter GUARD_CYCLES, default 2: cycles with all FTDI enables low between grants.
REQ-003 clock  in  1  rising-edge system clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 clear  in  1  synchronous clear.
REQ-006 rx_req  in  1  RX consumer requests a host-to-FPGA packet.
REQ-007 rx_len  in  10  RX bytes requested.
REQ-008 rx_done  out  1  one-cycle pulse when the RX packet is complete or aborted.
REQ-009 rx_count  out  10  bytes received in the last RX grant.
REQ-010 tx_req  in  1  TX producer requests an FPGA-to-host packet.
REQ-011 tx_len  in  10  TX bytes to send.
REQ-012 tx_data / tx_data_valid  in  8 / 1  TX byte and its qualifier.
REQ-013 tx_data_ack  out  1  one-cycle pulse when the current TX byte is consumed.
REQ-014 tx_done  out  1  one-cycle pulse when the TX packet is complete or aborted.
REQ-015 err_timeout  out  1  one-cycle pulse, coincident with the done pulse, on abort.
REQ-016 ftdi_rd_en, ftdi_wr_en  out  1 each  FTDI interface read and write enables.
REQ-017 ftdi_max_rd_ct  out  10  read limit to the FTDI interface.
REQ-018 ftdi_rd_ct_clear  out  1  clears the FTDI read counter and read register.
REQ-019 ftdi_rd_ct  in  10  FTDI bytes read so far.
REQ-020 ftdi_wr_ack  in  1  FTDI per-byte write-accepted pulse.
REQ-021 ftdi_data_wr / ftdi_data_wr_valid  out  8 / 1  byte to the FTDI interface and its qualifier.

Function
REQ-022 States: IDLE, RX_START, RX_ACTIVE, TX_ACTIVE, GUARD.
REQ-023 IDLE: requests are sampled each cycle; the grant takes effect on the next cycle.
- rx_req only -> RX_START.
- tx_req only -> TX_ACTIVE.
- Both -> the requester not granted last (round-robin).
REQ-024 Round-robin last-grant flag resets to TX, so RX wins the first simultaneous request.
REQ-025 Zero-length request (len==0):
- Matching done pulse on the next cycle; no FTDI enable is asserted.
- Counts as a grant for round-robin.
REQ-026 RX_START, one cycle:
- ftdi_rd_ct_clear=1.
- Latch eff_len=min(rx_len,512) into ftdi_max_rd_ct.
- Next state RX_ACTIVE.
REQ-027 RX_ACTIVE:
- ftdi_rd_en=1.
- When ftdi_rd_ct>=eff_len: rx_count<=ftdi_rd_ct, rx_done pulses, -> GUARD.
REQ-028 TX_ACTIVE:
- ftdi_wr_en=1, ftdi_data_wr=tx_data.
- ftdi_data_wr_valid=tx_data_valid && sent<tx_len (tx_len latched at grant).
- tx_data_ack=ftdi_wr_ack.
- sent increments on each ftdi_wr_ack.
- When sent==tx_len: tx_done pulses, -> GUARD.
REQ-029 Progress timer:
- Reloads on grant, on each ftdi_rd_ct change in RX_ACTIVE, and on each ftdi_wr_ack in TX_ACTIVE.
- On reaching TIMEOUT_CYCLES: done pulse plus err_timeout, -> GUARD.
- After an RX abort, rx_count=ftdi_rd_ct at the abort cycle.
REQ-030 GUARD:
- All FTDI enables and valids low for exactly GUARD_CYCLES cycles, then -> IDLE.
- Requests are ignored during GUARD.
REQ-031 ftdi_rd_en and ftdi_wr_en are never high in the same cycle.
REQ-032 Outside TX_ACTIVE: ftdi_data_wr_valid=0; ftdi_wr_ack is ignored and produces no tx_data_ack.
REQ-033 Request deassertion mid-grant does not shorten the transfer; only completion or timeout ends a grant.
REQ-034 Counters are 10 bits with no wrap; sent never exceeds tx_len.

Reset
REQ-035 While reset_n=0, asynchronously:
- State IDLE.
- All outputs 0, including ftdi_max_rd_ct and rx_count.
- Counters 0; last-grant flag TX.
REQ-036 clear=1 at a clock edge:
- Same state as reset, except rx_count is held.
- No done or err pulses.
- Takes priority over every transition.
REQ-037 Reset or clear mid-grant drops all FTDI enables on that edge, or immediately for reset_n.

Verification
REQ-038 rx_req=1, rx_len=64; ftdi_rd_ct counts 0..64 -> ftdi_rd_ct_clear 1 cycle, max_rd_ct=64, rd_en high until the count reaches 64, then rx_done, rx_count=64, 2 guard cycles.
REQ-039 tx_req=1, tx_len=3, tx_data_valid=1, three ftdi_wr_ack pulses -> three tx_data_ack pulses, valid low after the third ack, tx_done once.
REQ-040 rx_req and tx_req both held from reset -> grants alternate RX, TX, RX, each separated by 2 guard cycles; rd_en and wr_en never overlap.
REQ-041 rx_len=700 -> ftdi_max_rd_ct=512; completion at ftdi_rd_ct=512.
REQ-042 TIMEOUT_CYCLES=16, TX grant with no acks -> tx_done and err_timeout together 16 cycles after grant; rx_len=0 -> rx_done next cycle with no rd_en.
REQ-043 reset_n low during RX_ACTIVE -> ftdi_rd_en drops without waiting for a clock edge, all outputs 0; clear during TX_ACTIVE -> IDLE next edge, no tx_done.
